demux_stream: RTL

Stream demultiplexer: the distribution-side counterpart of the packed-input `mux_module`. It accepts one WIDTH-bit word per cycle over a valid/ready handshake, steers it to one of 2^n output channels by `in_select`, and buffers each channel in an independent 2-entry FIFO. It sits between a single producer (e.g. write-back or bus request source) and several consumers. Its packed output vector uses the same channel layout as `mux_module`'s input vector, so the two compose directly.

---
 rtl/demux_stream.sv | 60 ++++++
 1 files changed

// File: rtl/demux_stream.sv
// demux_stream: valid/ready stream steered by in_select into 2^n independent 2-entry FIFOs
// clk, rst_n      : rising-edge clock, synchronous active-low reset
// in_valid/ready  : producer handshake; in_select picks the channel, in_data is the word
// out_valid/ready : per-channel consumer handshake, bit k for channel k
// out_data        : packed FIFO heads, channel k at out_data[k*WIDTH +: WIDTH]
// xfer_count      : accepted-word counter, wraps
module demux_stream #(
  parameter int n     = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [n-1:0]             in_select,
  input  logic [WIDTH-1:0]         in_data,
  output logic [(1<<n)-1:0]        out_valid,
  input  logic [(1<<n)-1:0]        out_ready,
  output logic [(1<<n)*WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]         xfer_count
);
  localparam int C = 1 << n;
  logic [1:0]       w_cnt [C];
  logic             w_push;
  logic [CNT_W-1:0] r_xfer;
  // in_ready looks only at registered occupancy, so a same-cycle pop on a full channel frees nothing
  always_comb begin
    in_ready = w_cnt[in_select] != 2'd2;
    w_push   = in_valid && in_ready;
  end
  assign xfer_count = r_xfer;
  always_ff @(posedge clk) r_xfer <= !rst_n ? '0 : r_xfer + CNT_W'(w_push);
  for (genvar g = 0; g < C; g++) begin : g_ch
    logic [1:0]       r_cnt;
    logic             r_rd, r_wr;
    logic [WIDTH-1:0] r_mem [2];
    logic             w_wr, w_rd;
    always_comb begin
      w_wr = w_push && in_select == n'(g);
      w_rd = r_cnt != 2'd0 && out_ready[g];
    end
    assign w_cnt[g]                    = r_cnt;
    assign out_valid[g]                = r_cnt != 2'd0;
    assign out_data[g*WIDTH +: WIDTH]  = r_mem[r_rd];
    always_ff @(posedge clk)
      if (!rst_n) begin
        r_cnt    <= '0;
        r_rd     <= 1'b0;
        r_wr     <= 1'b0;
        r_mem[0] <= '0;
        r_mem[1] <= '0;
      end else begin
        if (w_wr) r_mem[r_wr] <= in_data;
        r_wr  <= r_wr ^ w_wr;
        r_rd  <= r_rd ^ w_rd;
        r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_rd};
      end
  end
endmodule
